// File: rtl/lfsr_range_rng.sv
// Galois LFSR random source with on-request bounded sampling in [0, limit].
// The LFSR free-runs while enabled and idle, can be reseeded at any time,
// and serves rejection-sampled values with a bounded fallback so latency
// never exceeds MAX_TRIES+1 cycles after an accepted request.
module lfsr_range_rng #(
  parameter int unsigned          WIDTH     = 10,
  parameter logic [WIDTH-1:0]     TAPS      = 10'h081,
  parameter logic [WIDTH-1:0]     SEED      = 10'd625,
  parameter int unsigned          MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] lfsr,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SAMPLE = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH-1:0] lim_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [TRY_W-1:0] tries_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_reg;
  logic [WIDTH-1:0] value_reg;
  logic             valid_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] fallback;
  logic             accept_req;

  // Mask = smallest 2^k-1 covering limit: smear every set bit of limit
  // down to bit 0 by OR-ing all right shifts of it.
  logic [WIDTH-1:0] smear [WIDTH];
  assign smear[0] = limit;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_smear
      assign smear[gi] = smear[gi-1] | (limit >> gi);
    end
  endgenerate
  assign mask_next = smear[WIDTH-1];

  // Galois step, seed sanitising and sample candidate evaluation.
  always_comb begin
    step_next  = {lfsr_reg[WIDTH-2:0], 1'b0} ^ (lfsr_reg[WIDTH-1] ? TAPS : '0);
    seed_fix   = (seed_in == '0) ? SEED : seed_in;
    cand       = lfsr_reg & mask_reg;
    // cand <= mask <= 2*limit+1 so this stays within [0, limit] when cand > limit
    fallback   = cand - lim_reg - WIDTH'(1);
    accept_req = (state_reg == ST_IDLE) && req;
  end

  // LFSR state: load wins; otherwise one step per cycle in SAMPLE, or
  // per enabled cycle in IDLE except the cycle a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (load) begin
      lfsr_reg <= seed_fix;
    end else if (state_reg == ST_SAMPLE) begin
      lfsr_reg <= step_next;
    end else if (!req && en) begin
      lfsr_reg <= step_next;
    end
  end

  // Sampling FSM: latch the bound, then test one candidate per non-load cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      lim_reg    <= '0;
      mask_reg   <= '0;
      tries_reg  <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept_req) begin
            lim_reg   <= limit;
            mask_reg  <= mask_next;
            tries_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // A reload freezes evaluation; sampling resumes from the new state.
          if (!load) begin
            if (cand <= lim_reg) begin
              result_reg <= cand;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= ST_IDLE;
            end else if (tries_reg == LAST_TRY) begin
              result_reg <= fallback;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= ST_IDLE;
            end else begin
              tries_reg <= tries_reg + TRY_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Result register: publish the decided value with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= done_reg;
      if (done_reg) begin
        value_reg <= result_reg;
      end
    end
  end

  assign lfsr  = lfsr_reg;
  assign value = value_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;

endmodule
